mem_ctrl: RTL

Memory-port controller on the initiator side of the CPU's shared memory-simulator interface. It accepts instruction-fetch requests from IF and load/store requests from MEM, arbitrates them onto the single memory port, and waits for the memory reply. It extracts the addressed 32-bit word from the 64-bit reply, acknowledges the requesting stage, and raises a pipeline stall while any request is outstanding.

---
 rtl/mem_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Initiator-side memory-port controller. Arbitrates IF fetches and MEM
// loads/stores onto one memory port, waits for the read reply (bounded by
// TIMEOUT cycles), extracts the addressed 32-bit word from the 64-bit reply
// line, and pulses the ack of the stage that owns the transaction.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   if_req_i/if_addr_i  : fetch request and byte address (held until ack)
//   if_ack_o/if_data_o  : fetch completion pulse and instruction word (held)
//   mem_req_i/mem_we_i  : MEM access request, 1 = store / 0 = load
//   mem_addr_i, mem_wdata_i, mem_mask_i : access address, store data, mask
//   mem_ack_o/mem_rdata_o : access completion pulse and load word (held)
//   stall_req_o         : pipeline stall while a request is not yet acked
//   timeout_o           : sticky, a read timed out since reset
//   ms_req_o, ms_addr_o : memory read request and latched address
//   ms_write_o, ms_write_data_o, ms_write_mask_o : one-cycle store strobe
//   ms_rep_i, ms_rep_data_i : reply valid and aligned 8-byte reply line
// -----------------------------------------------------------------------------
module mem_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_data_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_mask_i,
    output logic        mem_ack_o,
    output logic [31:0] mem_rdata_o,
    output logic        stall_req_o,
    output logic        timeout_o,
    output logic        ms_req_o,
    output logic [31:0] ms_addr_o,
    output logic        ms_write_o,
    output logic [31:0] ms_write_data_o,
    output logic [3:0]  ms_write_mask_o,
    input  logic        ms_rep_i,
    input  logic [63:0] ms_rep_data_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef enum logic {
        SRC_IF  = 1'b0,
        SRC_MEM = 1'b1
    } src_t;

    // Last counter value before a read is forced to complete.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 32'd1);

    state_t      state_q;
    src_t        src_q;
    src_t        last_q;
    logic [15:0] cnt_q;
    logic        if_ack_q;
    logic        mem_ack_q;
    logic [31:0] if_data_q;
    logic [31:0] mem_rdata_q;
    logic        timeout_q;
    logic        ms_req_q;
    logic [31:0] ms_addr_q;
    logic        ms_write_q;
    logic [31:0] ms_wdata_q;
    logic [3:0]  ms_mask_q;

    logic [31:0] rd_word_s;
    logic        pick_mem_s;
    logic        rd_done_s;

    // Word select from the reply line, arbitration choice and read completion.
    always_comb begin
        // Timed-out reads complete with zero data.
        rd_word_s = ms_rep_i ? (ms_addr_q[2] ? ms_rep_data_i[63:32] : ms_rep_data_i[31:0])
                             : 32'h0000_0000;
        rd_done_s = ms_rep_i || (cnt_q == TO_LAST);
        // MEM wins when alone, or on a tie when IF was granted last.
        if (mem_req_i && (!if_req_i || (last_q == SRC_IF))) begin
            pick_mem_s = 1'b1;
        end else begin
            pick_mem_s = 1'b0;
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_IF;
            last_q      <= SRC_IF;
            cnt_q       <= 16'd0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_data_q   <= 32'h0000_0000;
            mem_rdata_q <= 32'h0000_0000;
            timeout_q   <= 1'b0;
            ms_req_q    <= 1'b0;
            ms_addr_q   <= 32'h0000_0000;
            ms_write_q  <= 1'b0;
            ms_wdata_q  <= 32'h0000_0000;
            ms_mask_q   <= 4'h0;
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= 16'd0;
                    if (pick_mem_s) begin
                        src_q      <= SRC_MEM;
                        last_q     <= SRC_MEM;
                        ms_addr_q  <= mem_addr_i;
                        ms_wdata_q <= mem_wdata_i;
                        ms_mask_q  <= mem_mask_i;
                        if (mem_we_i) begin
                            ms_write_q <= 1'b1;
                            state_q    <= ST_WR;
                        end else begin
                            ms_req_q   <= 1'b1;
                            state_q    <= ST_RD;
                        end
                    end else if (if_req_i) begin
                        src_q     <= SRC_IF;
                        last_q    <= SRC_IF;
                        ms_addr_q <= if_addr_i;
                        ms_req_q  <= 1'b1;
                        state_q   <= ST_RD;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (rd_done_s) begin
                        ms_req_q  <= 1'b0;
                        timeout_q <= timeout_q | ~ms_rep_i;
                        state_q   <= ST_RESP;
                        if (src_q == SRC_IF) begin
                            if_data_q <= rd_word_s;
                            if_ack_q  <= 1'b1;
                        end else begin
                            mem_rdata_q <= rd_word_s;
                            mem_ack_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_WR: begin
                    ms_write_q <= 1'b0;
                    state_q    <= ST_RESP;
                    if (src_q == SRC_IF) begin
                        if_ack_q  <= 1'b1;
                    end else begin
                        mem_ack_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    ms_req_q   <= 1'b0;
                    ms_write_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_ack_o        = if_ack_q;
    assign mem_ack_o       = mem_ack_q;
    assign if_data_o       = if_data_q;
    assign mem_rdata_o     = mem_rdata_q;
    assign timeout_o       = timeout_q;
    assign ms_req_o        = ms_req_q;
    assign ms_addr_o       = ms_addr_q;
    assign ms_write_o      = ms_write_q;
    assign ms_write_data_o = ms_wdata_q;
    assign ms_write_mask_o = ms_mask_q;
    assign stall_req_o     = (if_req_i & ~if_ack_q) | (mem_req_i & ~mem_ack_q);

endmodule
